// File: rtl/pipe_adder_n.sv
// Segmented carry-ripple adder: one SEG-bit slice per pipeline stage, valid/ready handshake.
// The whole pipeline advances together whenever the output register is free or being consumed.
module pipe_adder_n #(
  parameter int WIDTH   = 32,
  parameter int STAGES  = 4,
  parameter int MSB_SEL = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   c
);

  localparam int SEG = WIDTH / STAGES;

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // Operand bits still to be added shrink by SEG per stage.
    localparam int SRC_W = WIDTH - gi * SEG;

    logic [SRC_W-1:0]        a_src;
    logic [SRC_W-1:0]        b_src;
    logic                    carry_src;
    logic                    sign_src;
    logic                    valid_src;
    logic [SEG:0]            seg_sum;
    logic [(gi+1)*SEG-1:0]   sum_next;
    logic                    carry_next;
    logic [(gi+1)*SEG-1:0]   sum_reg;
    logic                    carry_reg;
    logic                    valid_reg;

    if (gi == 0) begin : g_first
      assign a_src     = a;
      assign b_src     = b;
      assign carry_src = 1'b0;
      assign sign_src  = sign;
      assign valid_src = in_valid;
      assign sum_next  = seg_sum[SEG-1:0];
    end else begin : g_next
      assign a_src     = g_stage[gi-1].g_ops.a_reg;
      assign b_src     = g_stage[gi-1].g_ops.b_reg;
      assign carry_src = g_stage[gi-1].carry_reg;
      assign sign_src  = g_stage[gi-1].g_ops.sign_reg;
      assign valid_src = g_stage[gi-1].valid_reg;
      assign sum_next  = {seg_sum[SEG-1:0], g_stage[gi-1].sum_reg};
    end

    assign seg_sum = {1'b0, a_src[SEG-1:0]} + {1'b0, b_src[SEG-1:0]}
                   + {{SEG{1'b0}}, carry_src};

    // In the output stage carry_reg becomes c[WIDTH]: either the true carry or the sign.
    assign carry_next = (gi == STAGES - 1 && MSB_SEL != 0) ? sign_src : seg_sum[SEG];

    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        sum_reg   <= '0;
        carry_reg <= 1'b0;
        valid_reg <= 1'b0;
      end else if (advance) begin
        sum_reg   <= sum_next;
        carry_reg <= carry_next;
        valid_reg <= valid_src;
      end
    end

    if (gi < STAGES - 1) begin : g_ops
      logic [SRC_W-SEG-1:0] a_reg;
      logic [SRC_W-SEG-1:0] b_reg;
      logic                 sign_reg;

      always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
          a_reg    <= '0;
          b_reg    <= '0;
          sign_reg <= 1'b0;
        end else if (advance) begin
          a_reg    <= a_src[SRC_W-1:SEG];
          b_reg    <= b_src[SRC_W-1:SEG];
          sign_reg <= sign_src;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign c         = {g_stage[STAGES-1].carry_reg, g_stage[STAGES-1].sum_reg};

endmodule
